// File: rtl/key_sched_ctrl.sv
// rtl/key_sched_ctrl.sv - AES key schedule expander with a 60-word round-key store
module key_sched_ctrl #(
  parameter int SBOX_LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         busy,
  output logic         ready,
  output logic         done,
  output logic         err,
  output logic [3:0]   nr,
  input  logic         rk_req,
  input  logic [3:0]   rk_idx,
  output logic         rk_valid,
  output logic [127:0] rk
);
  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, READY} state_t;
  state_t state, state_nxt;

  logic [1:0]   klen_q;
  logic [255:0] key_q;
  logic [31:0]  w_mem [0:59];
  logic [5:0]   widx, mod_cnt, nk, rbase;
  logic [7:0]   rcon;
  logic [31:0]  w_prev, w_back, sub_in, sub_out, temp, w_new;
  logic         accept, key_ok, last_word, rd_fire;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box = affine(x^254); x^254 is the GF(2^8) inverse and maps 0 to 0
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign nk        = 6'd4 + {3'b000, klen_q, 1'b0};
  assign accept    = start && (state == IDLE || state == READY);
  assign key_ok    = (key_len != 2'b11);
  assign last_word = (widx == {nr, 2'b11});
  assign rd_fire   = rk_req && !start && (state == READY);
  assign rbase     = {rk_idx, 2'b00};

  assign w_prev = w_mem[widx - 6'd1];
  assign w_back = w_mem[widx - nk];
  assign sub_in = (mod_cnt == 6'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  // one SubWord unit shared by the rotated and the 256-bit mid-block cases
  for (genvar l = 0; l < SBOX_LANES; l++) begin : g_sbox
    assign sub_out[8*l +: 8] = sbox(sub_in[8*l +: 8]);
  end

  always_comb begin
    temp = w_prev;
    if (mod_cnt == 6'd0)
      temp = sub_out ^ {rcon, 24'h000000};
    else if (nk == 6'd8 && mod_cnt == 6'd4)
      temp = sub_out;
  end
  assign w_new = w_back ^ temp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, READY: if (accept) state_nxt = key_ok ? LOAD : IDLE;
      LOAD:        state_nxt = EXPAND;
      EXPAND:      if (last_word) state_nxt = READY;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == LOAD) || (state == EXPAND);
    ready = (state == READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      klen_q   <= 2'b00;
      key_q    <= '0;
      nr       <= 4'd0;
      widx     <= 6'd0;
      mod_cnt  <= 6'd0;
      rcon     <= 8'h00;
      done     <= 1'b0;
      err      <= 1'b0;
      rk_valid <= 1'b0;
      rk       <= '0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      rk_valid <= 1'b0;
      if (accept) begin
        if (key_ok) begin
          klen_q <= key_len;
          key_q  <= key;
        end else begin
          err <= 1'b1;
        end
      end
      case (state)
        LOAD: begin
          nr      <= 4'd10 + {1'b0, klen_q, 1'b0};
          widx    <= nk;
          mod_cnt <= 6'd0;
          rcon    <= 8'h01;
        end
        EXPAND: begin
          widx    <= widx + 6'd1;
          mod_cnt <= (mod_cnt == nk - 6'd1) ? 6'd0 : mod_cnt + 6'd1;
          if (mod_cnt == 6'd0) rcon <= xtime(rcon);
          if (last_word) done <= 1'b1;
        end
        default: ;
      endcase
      if (rd_fire) begin
        rk_valid <= 1'b1;
        if (rk_idx <= nr) begin
          rk <= {w_mem[rbase], w_mem[rbase + 6'd1], w_mem[rbase + 6'd2], w_mem[rbase + 6'd3]};
        end else begin
          rk  <= '0;
          err <= 1'b1;
        end
      end
    end
  end

  // the key words beyond nk are written too but always overwritten before use
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      for (int j = 0; j < 8; j++) w_mem[j] <= key_q[255 - 32*j -: 32];
    end else if (state == EXPAND) begin
      w_mem[widx] <= w_new;
    end
  end
endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb/tb_key_sched_ctrl.sv - randomized scoreboard bench for key_sched_ctrl
module tb_key_sched_ctrl;
  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk = 1'b0, rst_n = 1'b1, start = 1'b0, rk_req = 1'b0;
  logic [1:0]   key_len = 2'b00;
  logic [255:0] key = '0;
  logic [3:0]   rk_idx = 4'd0;
  logic         busy, ready, done, err, rk_valid;
  logic [3:0]   nr;
  logic [127:0] rk;

  typedef struct packed {logic [127:0] rk; logic err;} rd_exp_t;
  rd_exp_t rd_q[$];
  int done_q[$];
  int err_q[$];
  int nchecks = 0, nerrs = 0, cyc = 0;
  logic [7:0]  sb [0:255];
  logic [31:0] ref_w [0:59];
  int ref_nr;

  key_sched_ctrl #(.SBOX_LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .ready(ready), .done(done), .err(err), .nr(nr),
    .rk_req(rk_req), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk(rk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  // classic generator walk: p steps through powers of 3, q through powers of 1/3
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  task automatic ref_expand(input logic [1:0] kl, input logic [255:0] k);
    int nkk;
    logic [31:0] t;
    logic [7:0] rc;
    nkk = 4 + 2 * int'(kl);
    ref_nr = nkk + 6;
    for (int i = 0; i < nkk; i++) ref_w[i] = k[255 - 32*i -: 32];
    for (int i = nkk; i < 4 * (ref_nr + 1); i++) begin
      t = ref_w[i-1];
      if (i % nkk == 0) begin
        rc = 8'h01;
        for (int r = 1; r < i / nkk; r++) rc = xt(rc);
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nkk == 8 && i % nkk == 4) begin
        t = subw(t);
      end
      ref_w[i] = ref_w[i-nkk] ^ t;
    end
  endtask

  function automatic rd_exp_t exp_rd(input logic [3:0] idx);
    rd_exp_t e;
    int b;
    b = 4 * int'(idx);
    if (int'(idx) > ref_nr) begin
      e.rk  = '0;
      e.err = 1'b1;
    end else begin
      e.rk  = {ref_w[b], ref_w[b+1], ref_w[b+2], ref_w[b+3]};
      e.err = 1'b0;
    end
    return e;
  endfunction

  task automatic do_start(input logic [1:0] kl, input logic [255:0] k, input bit acc);
    start = 1'b1;
    key_len = kl;
    key = k;
    if (acc) begin
      if (kl == 2'b11) err_q.push_back(cyc);
      else begin
        ref_expand(kl, k);
        done_q.push_back(cyc + 41 + 6 * int'(kl));
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx);
    rk_req = 1'b1;
    rk_idx = idx;
    rd_q.push_back(exp_rd(idx));
    @(negedge clk);
    rk_req = 1'b0;
  endtask

  task automatic rd_exp(input logic [3:0] idx, input logic [127:0] v, input logic e);
    rd_exp_t x;
    x.rk = v;
    x.err = e;
    rk_req = 1'b1;
    rk_idx = idx;
    rd_q.push_back(x);
    @(negedge clk);
    rk_req = 1'b0;
  endtask

  task automatic rd_none(input logic [3:0] idx, input string nm);
    rk_req = 1'b1;
    rk_idx = idx;
    @(negedge clk);
    rk_req = 1'b0;
    chkb({nm, "_rk_valid"}, rk_valid, 1'b0);
    chkb({nm, "_err"}, err, 1'b0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chkb("ready_wait", ready, 1'b1);
  endtask

  task automatic chk_all_zero(input string nm);
    chkb({nm, "_busy"}, busy, 1'b0);
    chkb({nm, "_ready"}, ready, 1'b0);
    chkb({nm, "_done"}, done, 1'b0);
    chkb({nm, "_err"}, err, 1'b0);
    chkb({nm, "_rk_valid"}, rk_valid, 1'b0);
    chk({nm, "_rk"}, rk, 128'h0);
    chki({nm, "_nr"}, int'(nr), 0);
  endtask

  always @(negedge clk) begin
    if (rk_valid) begin
      if (rd_q.size() == 0) begin
        nchecks++;
        nerrs++;
        $display("FAIL rk_valid_unexpected: got 1 expected 0");
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        chk("rk", rk, e.rk);
        chkb("rk_err", err, e.err);
      end
    end else if (err) begin
      if (err_q.size() == 0) begin
        nchecks++;
        nerrs++;
        $display("FAIL err_unexpected: got 1 expected 0");
      end else chki("err_edge", cyc - 1, err_q.pop_front());
    end
    if (done) begin
      if (done_q.size() == 0) begin
        nchecks++;
        nerrs++;
        $display("FAIL done_unexpected: got 1 expected 0");
      end else begin
        chki("done_edge", cyc - 1, done_q.pop_front());
        chkb("done_ready", ready, 1'b1);
        chkb("done_busy", busy, 1'b0);
      end
    end
  end

  initial begin
    logic [1:0] kl;
    logic [255:0] rk_key;
    build_sbox();
    #1 rst_n = 1'b0;
    #2 chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 128-bit vector with an ignored read and an ignored start mid-expansion
    do_start(2'b00, K128, 1'b1);
    repeat (4) @(negedge clk);
    rd_none(4'd0, "rd_in_expand");
    repeat (3) @(negedge clk);
    do_start(2'b01, K192, 1'b0);
    chkb("busy_after_ignored_start", busy, 1'b1);
    wait_ready();
    chki("nr128", int'(nr), 10);
    rd_exp(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0);
    rd_exp(4'd11, 128'h0, 1'b1);
    for (int i = 0; i <= 10; i++) rd(4'(i));

    do_start(2'b01, K192, 1'b1);
    wait_ready();
    chki("nr192", int'(nr), 12);
    rd_exp(4'd12, 128'he98ba06f448c773c8ecc720401002202, 1'b0);
    rd_exp(4'd13, 128'h0, 1'b1);

    do_start(2'b10, K256, 1'b1);
    wait_ready();
    chki("nr256", int'(nr), 14);
    rd_exp(4'd0, 128'h603deb1015ca71be2b73aef0857d7781, 1'b0);
    rd_exp(4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b0);
    rd(4'd15);

    do_start(2'b11, K256, 1'b1);
    chkb("reserved_ready", ready, 1'b0);
    chkb("reserved_busy", busy, 1'b0);
    rd_none(4'd2, "rd_after_reserved");

    // asynchronous reset in the middle of expansion, then immediate restart
    do_start(2'b00, K128, 1'b1);
    repeat (20) @(negedge clk);
    chkb("busy_before_reset", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    done_q.delete();
    rd_q.delete();
    err_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_start(2'b00, K128, 1'b1);
    wait_ready();
    rd_exp(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0);

    // start wins over a same-cycle read in READY
    rk_req = 1'b1;
    rk_idx = 4'd3;
    do_start(2'b10, K256, 1'b1);
    rk_req = 1'b0;
    chkb("start_vs_rd_busy", busy, 1'b1);
    chkb("start_vs_rd_rk_valid", rk_valid, 1'b0);
    wait_ready();
    rd_exp(4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b0);

    for (int t = 0; t < 6; t++) begin
      kl = 2'($urandom_range(0, 2));
      rk_key = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
      do_start(kl, rk_key, 1'b1);
      wait_ready();
      chki("nr_rand", int'(nr), ref_nr);
      repeat (12) begin
        rd(4'($urandom_range(0, 15)));
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    chki("rd_q_drained", rd_q.size(), 0);
    chki("done_q_drained", done_q.size(), 0);
    chki("err_q_drained", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end
endmodule
